// File: rtl/load_store_unit.sv
// Load/store responder for the multicycle RV64 core: lane extraction,
// sign/zero extension, read-modify-write for partial stores.
module load_store_unit #(
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [63:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [2:0]    off_q, off_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [63:0]   mwdata_q, mwdata_d;

  logic          legal, aligned, acc_err;
  logic [63:0]   sh, ext, rep, merged;
  logic [7:0]    be;

  always_comb begin
    legal = we ? ~funct3[2] : (funct3 != 3'b111);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = (addr[2:0] == 3'b000);
    endcase
    acc_err = ~legal | ~aligned;
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    sh = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{56{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ext = {{32{sh[31]}}, sh[31:0]};
      3'b100:  ext = {56'b0, sh[7:0]};
      3'b101:  ext = {48'b0, sh[15:0]};
      3'b110:  ext = {32'b0, sh[31:0]};
      default: ext = sh;
    endcase
  end

  // Store path: replicate data across lanes, byte-enable picks the target.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be  = 8'h01 << off_q;
        rep = {8{wdata_q[7:0]}};
      end
      2'b01: begin
        be  = 8'h03 << off_q;
        rep = {4{wdata_q[15:0]}};
      end
      2'b10: begin
        be  = 8'h0F << off_q;
        rep = {2{wdata_q[31:0]}};
      end
      default: begin
        be  = 8'hFF;
        rep = wdata_q;
      end
    endcase
    merged = mem_rdata;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) merged[i*8 +: 8] = rep[i*8 +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          off_d   = addr[2:0];
          wdata_d = wdata;
          maddr_d = {addr[AW-1:3], 3'b000};
          err_d   = acc_err;
          if (acc_err) begin
            state_d = RESP;
          end else if (we && funct3 == 3'b011) begin
            state_d  = WRITE;
            mwdata_d = wdata;
          end else begin
            state_d = READ;
            cnt_d   = 4'(MEM_LAT);
          end
        end
      end
      READ: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (we_q) begin
            mwdata_d = merged;
            state_d  = WRITE;
          end else begin
            rdata_d = ext;
            state_d = RESP;
          end
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      off_q    <= 3'b000;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign err       = done & err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_we    = (state_q == WRITE);
  assign mem_wdata = mwdata_q;

endmodule
